// File: rtl/b1553_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// b1553_bus_arbiter_pkg
// Shared definitions for the 1553B host-bus arbiter:
//   - bus widths and the read data returned on a timeout abort
//   - one-hot FSM state encoding
//   - the per-access request bundle latched at grant time
//   - idx_width(): index width for an N-way requester set (minimum 1 bit)
// -----------------------------------------------------------------------------
package b1553_bus_arbiter_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] ERR_RDATA = 16'hFFFF;

  // One-hot so each state decodes from a single flop.
  typedef enum logic [7:0] {
    ST_RSTSEQ   = 8'b0000_0001,
    ST_IDLE     = 8'b0000_0010,
    ST_SETUP    = 8'b0000_0100,
    ST_STROBE   = 8'b0000_1000,
    ST_WAIT_RDY = 8'b0001_0000,
    ST_HOLD     = 8'b0010_0000,
    ST_ABORT    = 8'b0100_0000,
    ST_TURN     = 8'b1000_0000
  } state_e;

  typedef struct packed {
    logic              wr;
    logic              mem;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } access_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/b1553_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// b1553_bus_arbiter_if
// Requester-side handshake bundle of the 1553B host-bus arbiter.
//   req       per-requester access request, held until its done
//   req_wr    1 = write, 0 = read
//   req_mem   1 = RAM space, 0 = register space
//   req_addr  chip address, requester i at [12i+11:12i]
//   req_wdata write data, requester i at [16i+15:16i]
//   done      1-cycle pulse to the owning requester at access end
//   err       valid with done: 1 = timeout abort
//   rdata     read data, valid with done, held until the next done
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface b1553_bus_arbiter_if
  import b1553_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ-1:0]        req_mem;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic [DATA_W-1:0]      rdata;

  modport master (
    output req, req_wr, req_mem, req_addr, req_wdata,
    input  done, err, rdata
  );

  modport slave (
    input  req, req_wr, req_mem, req_addr, req_wdata,
    output done, err, rdata
  );

endinterface

// File: rtl/b1553_rr_arbiter.sv
// -----------------------------------------------------------------------------
// b1553_rr_arbiter
// Combinational round-robin pick among NREQ requesters. The search starts at
// ptr+1 (mod NREQ), so the last winner has lowest priority next time.
//   req       request vector
//   ptr       index of the previous grant
//   grant     one-hot grant (all zero when no request)
//   grant_idx binary index of the grant
//   any       at least one request present
// -----------------------------------------------------------------------------
module b1553_rr_arbiter
  import b1553_bus_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default first so no path through the loop
    // leaves one unassigned and infers a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/b1553_bus_arbiter.sv
// -----------------------------------------------------------------------------
// b1553_bus_arbiter
// Owns the 1553B protocol chip's parallel host bus: round-robin shares it
// between NREQ requesters, sequences each access (setup / strobe / wait RDYn /
// hold / turnaround) and sequences the chip reset. Sole driver of CSn.
// Ports:
//   HCLK, HRESETn   clock, async active-low reset
//   host            requester handshake bundle (slave side)
//   soft_rst        pulse: request a chip reset sequence (honoured in IDLE)
//   busy            1 while not idle or while the chip reset is running
//   B1553_*         chip pins; DATA_O/DATA_DIR feed the pad tristate,
//                   B1553_RDYn is asynchronous and synchronised here
// All pin and handshake outputs are registered.
// -----------------------------------------------------------------------------
module b1553_bus_arbiter
  import b1553_bus_arbiter_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int TIMEOUT    = 255,
  parameter int TURNAROUND = 1,
  parameter int RST_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  b1553_bus_arbiter_if.slave host,
  input  logic              soft_rst,
  output logic              busy,
  output logic [ADDR_W-1:0] B1553_ADDR,
  output logic [DATA_W-1:0] B1553_DATA_O,
  output logic              B1553_DATA_DIR,
  input  logic [DATA_W-1:0] B1553_DATA_I,
  output logic              B1553_CSn,
  output logic              B1553_RD_WRn,
  output logic              B1553_MEM_REGn,
  output logic              B1553_RSTn,
  input  logic              B1553_RDYn
);

  localparam int IDX_W = idx_width(NREQ);

  state_e            state;
  logic [7:0]        cnt;        // shared: reset length, RDYn timeout, turnaround
  logic [IDX_W-1:0]  ptr;
  logic [NREQ-1:0]   own;        // one-hot owner of the access in flight
  logic              own_wr;
  logic [NREQ-1:0]   done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdy_meta;
  logic              rdy_sync;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_req;
  access_t           pick;

  b1553_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (host.req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Request fields of the requester the arbiter would grant this cycle.
  always_comb begin
    pick.wr    = host.req_wr[grant_idx];
    pick.mem   = host.req_mem[grant_idx];
    pick.addr  = host.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    pick.wdata = host.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
  end

  assign host.done  = done_q;
  assign host.err   = err_q;
  assign host.rdata = rdata_q;

  // RDYn is asynchronous to HCLK; resets to "not ready".
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdy_meta <= 1'b1;
      rdy_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge value; blocking here would collapse the two sync stages.
      rdy_meta <= B1553_RDYn;
      rdy_sync <= rdy_meta;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state          <= ST_RSTSEQ;
      cnt            <= '0;
      ptr            <= '0;
      own            <= '0;
      own_wr         <= 1'b0;
      done_q         <= '0;
      err_q          <= 1'b0;
      rdata_q        <= '0;
      busy           <= 1'b1;
      B1553_CSn      <= 1'b1;
      B1553_RD_WRn   <= 1'b1;
      B1553_DATA_DIR <= 1'b0;
      B1553_MEM_REGn <= 1'b0;
      B1553_ADDR     <= '0;
      B1553_DATA_O   <= '0;
      B1553_RSTn     <= 1'b0;
    end else begin
      // done/err are single-cycle pulses unless a state below raises them.
      done_q <= '0;
      err_q  <= 1'b0;

      case (state)
        ST_RSTSEQ: begin
          busy <= 1'b1;
          if (cnt == 8'(RST_CYCLES - 1)) begin
            B1553_RSTn <= 1'b1;
            cnt        <= '0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_IDLE: begin
          if (soft_rst) begin
            // Reset beats a simultaneous request; the request stays pending.
            B1553_RSTn <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= ST_RSTSEQ;
          end else if (any_req) begin
            ptr            <= grant_idx;
            own            <= grant;
            own_wr         <= pick.wr;
            B1553_ADDR     <= pick.addr;
            B1553_MEM_REGn <= pick.mem;
            B1553_RD_WRn   <= ~pick.wr;
            B1553_DATA_DIR <= pick.wr;
            B1553_DATA_O   <= pick.wdata;
            busy           <= 1'b1;
            state          <= ST_SETUP;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_SETUP: begin
          B1553_CSn <= 1'b0;
          state     <= ST_STROBE;
        end

        ST_STROBE: begin
          cnt   <= '0;
          state <= ST_WAIT_RDY;
        end

        // cnt counts WAIT_RDY cycles from 0, so TIMEOUT unready cycles abort.
        ST_WAIT_RDY: begin
          if (!rdy_sync) begin
            B1553_CSn <= 1'b1;
            done_q    <= own;
            if (!own_wr) rdata_q <= B1553_DATA_I;
            state     <= ST_HOLD;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            B1553_CSn <= 1'b1;
            done_q    <= own;
            err_q     <= 1'b1;
            rdata_q   <= ERR_RDATA;
            state     <= ST_ABORT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // Write data stays on DATA_O until the next SETUP; only direction,
        // strobe polarity and address return to idle here.
        ST_HOLD, ST_ABORT: begin
          B1553_DATA_DIR <= 1'b0;
          B1553_RD_WRn   <= 1'b1;
          B1553_ADDR     <= '0;
          cnt            <= '0;
          state          <= (TURNAROUND == 0) ? ST_IDLE : ST_TURN;
        end

        ST_TURN: begin
          if (cnt == 8'(TURNAROUND - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          B1553_CSn  <= 1'b1;
          B1553_RSTn <= 1'b0;
          cnt        <= '0;
          state      <= ST_RSTSEQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b1553_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_b1553_bus_arbiter
// Self-checking bench for b1553_bus_arbiter. A small chip model answers CSn
// with RDYn after a programmable delay and returns address-derived read data.
// Expected accesses are queued when requests are driven; a monitor compares
// the pins while CSn is low and pops/compares at each done pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_b1553_bus_arbiter;
  import b1553_bus_arbiter_pkg::*;

  localparam int NREQ       = 2;
  localparam int TIMEOUT    = 255;
  localparam int RST_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_rst;
  logic        busy;
  logic [11:0] addr_pin;
  logic [15:0] data_o;
  logic        data_dir;
  logic [15:0] data_i;
  logic        csn;
  logic        rd_wrn;
  logic        mem_regn;
  logic        rstn;
  logic        rdyn = 1'b1;

  always #5 clk = ~clk;

  b1553_bus_arbiter_if #(.NREQ(NREQ)) host_if ();

  b1553_bus_arbiter #(
    .NREQ       (NREQ),
    .TIMEOUT    (TIMEOUT),
    .TURNAROUND (1),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .HCLK           (clk),
    .HRESETn        (rst_n),
    .host           (host_if),
    .soft_rst       (soft_rst),
    .busy           (busy),
    .B1553_ADDR     (addr_pin),
    .B1553_DATA_O   (data_o),
    .B1553_DATA_DIR (data_dir),
    .B1553_DATA_I   (data_i),
    .B1553_CSn      (csn),
    .B1553_RD_WRn   (rd_wrn),
    .B1553_MEM_REGn (mem_regn),
    .B1553_RSTn     (rstn),
    .B1553_RDYn     (rdyn)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // ---------------- chip model ----------------
  function automatic logic [15:0] chip_data(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A5A;
  endfunction

  logic chip_respond = 1'b1;
  int   chip_delay   = 3;
  int   cs_cnt       = 0;

  assign data_i = csn ? 16'h0000 : chip_data(addr_pin);

  always @(negedge clk) begin
    if (!csn) begin
      cs_cnt++;
      if (chip_respond && cs_cnt >= chip_delay) rdyn = 1'b0;
    end else begin
      cs_cnt = 0;
      rdyn   = 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          idx;
    logic        wr;
    logic        mem;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        err;
    int          cs_len;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] mon_want;
  logic [15:0] model_rdata = '0;
  int          cs_run = 0;
  int          left[NREQ];

  always @(negedge clk) begin
    if (!rst_n) begin
      cs_run      = 0;
      model_rdata = '0;
    end else begin
      check("dir_vs_rdwr", 32'(data_dir & rd_wrn), 32'd0);
      if (!csn) begin
        cs_run++;
        if (exp_q.size() == 0) begin
          check("cs_unexpected", 32'(csn), 32'd1);
        end else begin
          check("pin_addr", 32'(addr_pin), 32'(exp_q[0].addr));
          check("pin_mem_regn", 32'(mem_regn), 32'(exp_q[0].mem));
          check("pin_rd_wrn", 32'(rd_wrn), 32'(!exp_q[0].wr));
          check("pin_data_dir", 32'(data_dir), 32'(exp_q[0].wr));
          if (exp_q[0].wr) check("pin_data_o", 32'(data_o), 32'(exp_q[0].wdata));
        end
      end
      if (host_if.done != '0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(host_if.done), 32'd0);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_want = mon_e.err ? ERR_RDATA : (mon_e.wr ? model_rdata : chip_data(mon_e.addr));
          check("done_owner", 32'(host_if.done), 32'(1 << mon_e.idx));
          check("done_err", 32'(host_if.err), 32'(mon_e.err));
          check("done_rdata", 32'(host_if.rdata), 32'(mon_want));
          check("cs_low_len", 32'(cs_run), 32'(mon_e.cs_len));
          model_rdata = mon_want;
        end
        cs_run = 0;
      end else begin
        check("rdata_held", 32'(host_if.rdata), 32'(model_rdata));
        check("err_idle", 32'(host_if.err), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_acc(input int idx, input logic wr, input logic mem,
                            input logic [11:0] a, input logic [15:0] wd,
                            input logic err, input int cs_len);
    exp_t e;
    e.idx = idx; e.wr = wr; e.mem = mem; e.addr = a; e.wdata = wd;
    e.err = err; e.cs_len = cs_len;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic wr, input logic mem,
                         input logic [11:0] a, input logic [15:0] wd, input int n);
    host_if.req_wr[idx]             = wr;
    host_if.req_mem[idx]            = mem;
    host_if.req_addr[idx*12 +: 12]  = a;
    host_if.req_wdata[idx*16 +: 16] = wd;
    left[idx]                       = n;
    host_if.req[idx]                = 1'b1;
  endtask

  // Each requester drops req once it has seen its last done.
  task automatic wait_dones(input int n, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (host_if.done[i]) begin
          seen++;
          if (left[i] > 0) left[i]--;
          if (left[i] == 0) host_if.req[i] = 1'b0;
        end
      end
    end
    check(tag, 32'(seen), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy !== 1'b0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_cs_low(input string tag);
    int cyc = 0;
    while (csn !== 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(csn), 32'd0);
  endtask

  // Counts negedge samples with RSTn low, starting with the current one.
  task automatic measure_rstn(input string tag);
    int low = 0;
    while (rstn === 1'b0 && low < 1000) begin
      check("csn_in_rstseq", 32'(csn), 32'd1);
      low++;
      @(negedge clk);
    end
    check(tag, 32'(low), 32'(RST_CYCLES));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    host_if.req       = '0;
    host_if.req_wr    = '0;
    host_if.req_mem   = '0;
    host_if.req_addr  = '0;
    host_if.req_wdata = '0;
    soft_rst          = 1'b0;
    for (int i = 0; i < NREQ; i++) left[i] = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(csn), 32'd1);
    check("rst_rd_wrn", 32'(rd_wrn), 32'd1);
    check("rst_data_dir", 32'(data_dir), 32'd0);
    check("rst_mem_regn", 32'(mem_regn), 32'd0);
    check("rst_addr", 32'(addr_pin), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_rstn", 32'(rstn), 32'd0);
    check("rst_done", 32'(host_if.done), 32'd0);
    check("rst_err", 32'(host_if.err), 32'd0);
    check("rst_rdata", 32'(host_if.rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Power-on chip reset length and busy release
    rst_n = 1'b1;
    measure_rstn("por_rstn_low_len");
    check("por_rstn_high", 32'(rstn), 32'd1);
    check("por_busy_still_high", 32'(busy), 32'd1);
    @(negedge clk);
    check("por_busy_falls", 32'(busy), 32'd0);

    // Single write from requester 0
    chip_delay = 3;
    expect_acc(0, 1'b1, 1'b0, 12'h005, 16'hA5A5, 1'b0, 5);
    set_req(0, 1'b1, 1'b0, 12'h005, 16'hA5A5, 1);
    wait_dones(1, "wr0_done_seen");
    wait_idle("wr0_idle");

    // Both requesters held: four reads alternate 1,0,1,0
    chip_delay = 2;
    expect_acc(1, 1'b0, 1'b0, 12'h021, 16'h0000, 1'b0, 4);
    expect_acc(0, 1'b0, 1'b1, 12'h010, 16'h0000, 1'b0, 4);
    expect_acc(1, 1'b0, 1'b0, 12'h021, 16'h0000, 1'b0, 4);
    expect_acc(0, 1'b0, 1'b1, 12'h010, 16'h0000, 1'b0, 4);
    set_req(0, 1'b0, 1'b1, 12'h010, 16'h0000, 2);
    set_req(1, 1'b0, 1'b0, 12'h021, 16'h0000, 2);
    wait_dones(4, "rr_done_seen");
    wait_idle("rr_idle");

    // RAM write at top address from requester 1 (rdata must stay unchanged)
    chip_delay = 1;
    expect_acc(1, 1'b1, 1'b1, 12'hFFF, 16'h5A3C, 1'b0, 3);
    set_req(1, 1'b1, 1'b1, 12'hFFF, 16'h5A3C, 1);
    wait_dones(1, "wr1_done_seen");
    wait_idle("wr1_idle");

    // Read whose requester drops req mid-access still completes
    chip_delay = 2;
    expect_acc(0, 1'b0, 1'b0, 12'h040, 16'h0000, 1'b0, 4);
    set_req(0, 1'b0, 1'b0, 12'h040, 16'h0000, 1);
    wait_cs_low("drop_cs_low");
    host_if.req[0] = 1'b0;
    wait_dones(1, "drop_done_seen");
    wait_idle("drop_idle");

    // RDYn never asserted: abort after TIMEOUT wait cycles
    chip_respond = 1'b0;
    expect_acc(1, 1'b0, 1'b0, 12'h123, 16'h0000, 1'b1, 1 + TIMEOUT);
    set_req(1, 1'b0, 1'b0, 12'h123, 16'h0000, 1);
    wait_dones(1, "tmo_done_seen");
    check("tmo_csn_high", 32'(csn), 32'd1);
    wait_idle("tmo_idle");
    chip_respond = 1'b1;

    // soft_rst and a request in the same IDLE cycle: reset first
    chip_delay = 3;
    expect_acc(1, 1'b0, 1'b1, 12'h0AA, 16'h0000, 1'b0, 5);
    soft_rst = 1'b1;
    set_req(1, 1'b0, 1'b1, 12'h0AA, 16'h0000, 1);
    @(negedge clk);
    soft_rst = 1'b0;
    measure_rstn("soft_rstn_low_len");
    wait_dones(1, "soft_req_done_seen");
    wait_idle("soft_idle");

    // HRESETn during WAIT_RDY of a write: pins drop at once, no done
    chip_respond = 1'b0;
    expect_acc(0, 1'b1, 1'b0, 12'h300, 16'h1234, 1'b0, 0);
    set_req(0, 1'b1, 1'b0, 12'h300, 16'h1234, 1);
    wait_cs_low("hrst_cs_low");
    repeat (5) @(negedge clk);
    check("hrst_dir_before", 32'(data_dir), 32'd1);
    rst_n = 1'b0;
    #1;
    check("hrst_csn", 32'(csn), 32'd1);
    check("hrst_data_dir", 32'(data_dir), 32'd0);
    check("hrst_rd_wrn", 32'(rd_wrn), 32'd1);
    check("hrst_addr", 32'(addr_pin), 32'd0);
    check("hrst_data_o", 32'(data_o), 32'd0);
    check("hrst_rstn", 32'(rstn), 32'd0);
    check("hrst_busy", 32'(busy), 32'd1);
    exp_q.delete();
    host_if.req = '0;
    left[0]     = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hrst_no_done", 32'(host_if.done), 32'd0);
    end
    chip_respond = 1'b1;
    rst_n = 1'b1;
    measure_rstn("hrst_rstn_low_len");
    wait_idle("final_idle");
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
